// File: rtl/upsample_pkg.sv
// Shared types and elaboration-time helpers for the nearest-neighbour upsample buffer.
package upsample_pkg;

   typedef logic bank_t;

   function automatic int out_w(input int in_w, input int factor);
      return in_w * factor;
   endfunction

   function automatic int out_h(input int in_h, input int factor);
      return in_h * factor;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nn_row_banks.sv
// Two-row ping-pong store: synchronous write port, combinational read port.
module nn_row_banks
   import upsample_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IN_W   = 64
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  bank_t                    wr_bank,
   input  logic [cnt_w(IN_W)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  bank_t                    rd_bank,
   input  logic [cnt_w(IN_W)-1:0]   rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem [2][IN_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/upsample_nn_stream_ub.sv
// Streaming nearest-neighbour upsampler: buffers two input rows and replays each
// row FACTOR times with every pixel repeated FACTOR times, with its own coordinates.
module upsample_nn_stream_ub
   import upsample_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IN_W   = 64,
   parameter int IN_H   = 64,
   parameter int FACTOR = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [15:0]       out_x,
   output logic [15:0]       out_y,
   output logic              out_last
);

   localparam int CW = cnt_w(IN_W);
   localparam int RW = cnt_w(IN_H);
   localparam int FW = cnt_w(FACTOR);
   localparam logic [CW-1:0] COL_MAX = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IN_H - 1);
   localparam logic [FW-1:0] REP_MAX = FW'(FACTOR - 1);

   logic [1:0]    full, full_nxt;
   bank_t         wr_bank, rd_bank;
   logic [CW-1:0] wr_col, src_col;
   logic [FW-1:0] rep_x, rep_y;
   logic [RW-1:0] src_row;
   logic [15:0]   x_q, y_q;

   logic wr_fire, rd_fire, wr_row_done;
   logic x_wrap, col_wrap, y_wrap, frame_wrap;

   assign in_ready    = !full[wr_bank];
   assign out_valid   = full[rd_bank];
   assign wr_fire     = in_valid & in_ready;
   assign rd_fire     = out_valid & out_ready;
   assign wr_row_done = wr_fire & (wr_col == COL_MAX);

   assign x_wrap      = (rep_x == REP_MAX);
   assign col_wrap    = x_wrap & (src_col == COL_MAX);
   assign y_wrap      = col_wrap & (rep_y == REP_MAX);
   assign frame_wrap  = y_wrap & (src_row == ROW_MAX);

   assign out_x    = x_q;
   assign out_y    = y_q;
   assign out_last = out_valid & frame_wrap;

   // Writer and reader never touch the same bank in one cycle, so both updates apply.
   always_comb begin
      full_nxt = full;
      if (wr_row_done)         full_nxt[wr_bank] = 1'b1;
      if (rd_fire && y_wrap)   full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full    <= '0;
         wr_bank <= '0;
         wr_col  <= '0;
      end else if (flush) begin
         full    <= '0;
         wr_bank <= '0;
         wr_col  <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            if (wr_col == COL_MAX) begin
               wr_col  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_col <= wr_col + CW'(1);
            end
         end
      end
   end

   // Read-side counter chain; out_x/out_y track it incrementally instead of multiplying.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_x   <= '0;
         src_col <= '0;
         rep_y   <= '0;
         src_row <= '0;
         rd_bank <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else if (flush) begin
         rep_x   <= '0;
         src_col <= '0;
         rep_y   <= '0;
         src_row <= '0;
         rd_bank <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else if (rd_fire) begin
         rep_x <= x_wrap ? '0 : rep_x + FW'(1);
         x_q   <= col_wrap ? '0 : x_q + 16'd1;
         if (x_wrap)   src_col <= col_wrap ? '0 : src_col + CW'(1);
         if (col_wrap) begin
            rep_y <= y_wrap ? '0 : rep_y + FW'(1);
            y_q   <= frame_wrap ? '0 : y_q + 16'd1;
         end
         if (y_wrap) begin
            src_row <= frame_wrap ? '0 : src_row + RW'(1);
            rd_bank <= ~rd_bank;
         end
      end
   end

   nn_row_banks #(
      .DATA_W (DATA_W),
      .IN_W   (IN_W)
   ) u_banks (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_bank (wr_bank),
      .wr_addr (wr_col),
      .wr_data (in_data),
      .rd_bank (rd_bank),
      .rd_addr (src_col),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_upsample_nn_stream_ub.sv
// Directed bench: a 4x2 x2 instance for most scenarios and a 2x1 x3 instance.
module tb_upsample_nn_stream_ub;

   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready, sel;
   logic [15:0] in_data;

   logic        a_in_ready, a_out_valid, a_out_last;
   logic [15:0] a_out_data, a_out_x, a_out_y;
   logic        b_in_ready, b_out_valid, b_out_last;
   logic [15:0] b_out_data, b_out_x, b_out_y;

   logic        s_in_ready, s_out_valid, s_out_last;
   logic [15:0] s_out_data, s_out_x, s_out_y;

   int n_tests = 0;
   int n_fail  = 0;
   int pix [32];
   int w, h, f;
   int acc4, first_v;
   logic saw_block;

   always #5 clk = ~clk;

   upsample_nn_stream_ub #(.DATA_W(16), .IN_W(4), .IN_H(2), .FACTOR(2)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
      .out_x(a_out_x), .out_y(a_out_y), .out_last(a_out_last)
   );

   upsample_nn_stream_ub #(.DATA_W(16), .IN_W(2), .IN_H(1), .FACTOR(3)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
      .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last)
   );

   assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign s_out_valid = sel ? b_out_valid : a_out_valid;
   assign s_out_last  = sel ? b_out_last  : a_out_last;
   assign s_out_data  = sel ? b_out_data  : a_out_data;
   assign s_out_x     = sel ? b_out_x     : a_out_x;
   assign s_out_y     = sel ? b_out_y     : a_out_y;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out_valid"}, 32'(s_out_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(s_in_ready),  32'd1);
      chk({tag, "_out_x"},     32'(s_out_x),     32'd0);
      chk({tag, "_out_y"},     32'(s_out_y),     32'd0);
      chk({tag, "_out_last"},  32'(s_out_last),  32'd0);
   endtask

   task automatic fill(input int base0, input int base1);
      for (int i = 0; i < 8; i++) begin
         pix[i]     = base0 + i;
         pix[i + 8] = base1 + i;
      end
   endtask

   // Drives npix pixels from pix[] and checks outputs against the replication model.
   task automatic run(input int npix, input int gap, input int stall_at, input int stall_len,
                      input int stop_at, input int budget);
      int pi, oi, gap_cnt, stall_cnt, cyc, nout, target, fs, fr, r, ox, oy, edata;
      pi = 0; oi = 0; gap_cnt = 0; stall_cnt = 0; cyc = 0;
      fs = w * h * f * f;
      nout = (npix / (w * h)) * fs;
      target = (stop_at >= 0) ? stop_at : nout;
      saw_block = 1'b0; acc4 = -1; first_v = -1;
      while (oi < target && cyc < budget) begin
         @(negedge clk);
         in_valid  = (pi < npix) && (gap_cnt == 0);
         in_data   = 16'(pix[(pi < npix) ? pi : 0]);
         if (gap_cnt > 0) gap_cnt--;
         out_ready = !(oi == stall_at && stall_cnt < stall_len);
         #1;
         fr = oi / fs; r = oi % fs;
         oy = r / (w * f); ox = r % (w * f);
         edata = pix[fr * w * h + (oy / f) * w + ox / f];
         if (s_out_valid && first_v < 0) first_v = cyc;
         if (s_out_valid && !out_ready) begin
            stall_cnt++;
            chk("hold_data", 32'(s_out_data), 32'(edata));
            chk("hold_x",    32'(s_out_x),    32'(ox));
            chk("hold_y",    32'(s_out_y),    32'(oy));
         end
         if (in_valid && !s_in_ready) saw_block = 1'b1;
         if (in_valid && s_in_ready) begin
            if (pi == w - 1) acc4 = cyc;
            pi++;
            gap_cnt = gap;
         end
         if (s_out_valid && out_ready) begin
            chk("data", 32'(s_out_data), 32'(edata));
            chk("x",    32'(s_out_x),    32'(ox));
            chk("y",    32'(s_out_y),    32'(oy));
            chk("last", 32'(s_out_last), (r == fs - 1) ? 32'd1 : 32'd0);
            oi++;
         end
         cyc++;
      end
      chk("outputs_done", 32'(oi), 32'(target));
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      in_data = '0;
      w = 4; h = 2; f = 2;
      repeat (3) @(negedge clk);
      chk_idle("in_reset");
      rst = 1'b0;
      @(negedge clk);
      chk_idle("after_reset");

      // Single frame, no stalls.
      fill(1, 11);
      run(8, 0, -1, 0, -1, 500);

      // Output stall at index 3 for 5 cycles with two frames queued.
      fill(1, 11);
      run(16, 0, 3, 5, -1, 1000);
      chk("in_ready_blocked", 32'(saw_block), 32'd1);

      // Input starvation: first output the cycle after the 4th pixel write.
      fill(21, 31);
      run(8, 3, -1, 0, -1, 1000);
      chk("first_valid_latency", 32'(first_v), 32'(acc4 + 1));

      // FACTOR=3, 2x1 instance.
      sel = 1'b1; w = 2; h = 1; f = 3;
      pix[0] = 9; pix[1] = 10;
      run(2, 0, -1, 0, -1, 200);
      sel = 1'b0; w = 4; h = 2; f = 2;

      // Flush mid-frame, then a fresh frame.
      fill(101, 111);
      run(8, 0, -1, 0, 10, 500);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk_idle("after_flush");
      fill(1, 11);
      run(8, 0, -1, 0, -1, 500);

      // Asynchronous reset between edges mid-row, then two back-to-back frames.
      fill(51, 61);
      run(8, 0, -1, 0, 5, 500);
      #2;
      rst = 1'b1;
      #1;
      chk_idle("async_reset");
      @(negedge clk);
      rst = 1'b0;
      fill(41, 71);
      run(16, 0, -1, 0, -1, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
